// File: rtl/hazard_pkg.sv
// Shared types and constants for the scoreboard-based hazard controller.
//   hz_state_t : debug state encoding (RUN/STALL/FLUSH/FREEZE)
//   DEF_*      : default latency / geometry constants
//   cnt_width  : width of a down-counter that must hold values 0..lat
package hazard_pkg;

    typedef enum logic [1:0] {
        HZ_RUN    = 2'd0,
        HZ_STALL  = 2'd1,
        HZ_FLUSH  = 2'd2,
        HZ_FREEZE = 2'd3
    } hz_state_t;

    localparam int unsigned DEF_REG_AW      = 5;
    localparam int unsigned DEF_ALU_LAT     = 1;
    localparam int unsigned DEF_LOAD_LAT    = 2;
    localparam int unsigned DEF_FLUSH_DEPTH = 1;

    // Counter width for values 0..lat; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned lat);
        return (lat < 1) ? 1 : $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/hz_scoreboard.sv
// Per-register pending-write scoreboard.
// Each tracked register owns a small down-counter holding the number of cycles until its
// pending result is forwardable to ID. r0 is never tracked and always reads as ready.
// Ports:
//   clk, rst_n          clock / asynchronous active-low reset
//   advance             pipe moves this cycle (counters decrement); low = hold everything
//   issue, is_load, dst a writing instruction leaves ID this cycle
//   rs, rt              source registers being looked up
//   rs_gt1, rs_gt0      rs counter > 1 / > 0 (0 for r0)
//   rt_gt1, rt_gt0      rt counter > 1 / > 0 (0 for r0)
module hz_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW   = DEF_REG_AW,
    parameter int unsigned ALU_LAT  = DEF_ALU_LAT,
    parameter int unsigned LOAD_LAT = DEF_LOAD_LAT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              advance,
    input  logic              issue,
    input  logic              is_load,
    input  logic [REG_AW-1:0] dst,
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] rt,
    output logic              rs_gt1,
    output logic              rs_gt0,
    output logic              rt_gt1,
    output logic              rt_gt0
);

    localparam int unsigned NREG = 2 ** REG_AW;
    localparam int unsigned CW   = cnt_width(LOAD_LAT);

    localparam logic [CW-1:0] ALU_L  = CW'(ALU_LAT);
    localparam logic [CW-1:0] LOAD_L = CW'(LOAD_LAT);
    localparam logic [CW-1:0] ONE    = CW'(1);

    logic [CW-1:0] cnt_q [NREG];
    logic [CW-1:0] cnt_d [NREG];
    logic [CW-1:0] issue_lat;

    assign issue_lat = is_load ? LOAD_L : ALU_L;

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            cnt_d[r] = cnt_q[r];
            if (advance) begin
                if (cnt_q[r] != '0) begin
                    cnt_d[r] = cnt_q[r] - 1'b1;
                end
                // New writer: keep whichever is later, the old (decremented) or new latency.
                if (issue && (r != 0) && (dst == REG_AW'(r)) && (cnt_d[r] < issue_lat)) begin
                    cnt_d[r] = issue_lat;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    always_comb begin
        rs_gt0 = (rs != '0) && (cnt_q[rs] != '0);
        rs_gt1 = (rs != '0) && (cnt_q[rs] > ONE);
        rt_gt0 = (rt != '0) && (cnt_q[rt] != '0);
        rt_gt1 = (rt != '0) && (cnt_q[rt] > ONE);
    end

endmodule

// File: rtl/hazard_scoreboard_ctrl.sv
// Clocked hazard controller beside the ID stage.
// Stalls dependent instructions using a pending-write scoreboard, holds if_nop for a
// configurable number of cycles after a taken redirect, and freezes the pipe on mem_busy.
// Priority: FREEZE > STALL > FLUSH > RUN. Outputs depend on inputs and registered counters
// only; hz_state is a registered copy of the winning condition, for debug.
// Optional feature: define HAZARD_STATS_EN to build the stall/flush cycle counters;
// otherwise stall_cycles and flush_cycles are tied to 0.
// Ports:
//   clk, rst_n                       clock / asynchronous active-low reset
//   id_valid, id_rs, id_rt           ID instruction and its sources
//   id_use_rs, id_use_rt, id_branch  source usage, operands needed in ID
//   id_dst, id_reg_write, id_mem_read destination, write enable, load flag
//   redirect                         taken branch/jump resolved in ID
//   mem_busy                         data memory not ready
//   pc_write, ifid_write             PC / IF-ID enables
//   idex_nop, if_nop                 bubble into ID/EX, flush of IF/ID
//   hz_state                         registered state (debug)
//   stall_cycles, flush_cycles       statistics (HAZARD_STATS_EN)
module hazard_scoreboard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW      = DEF_REG_AW,
    parameter int unsigned ALU_LAT     = DEF_ALU_LAT,
    parameter int unsigned LOAD_LAT    = DEF_LOAD_LAT,
    parameter int unsigned FLUSH_DEPTH = DEF_FLUSH_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_branch,
    input  logic [REG_AW-1:0] id_dst,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              redirect,
    input  logic              mem_busy,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              idex_nop,
    output logic              if_nop,
    output logic [1:0]        hz_state,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       flush_cycles
);

    localparam int unsigned FCW = cnt_width(FLUSH_DEPTH);
    localparam logic [FCW-1:0] FLUSH_RELOAD = FCW'(FLUSH_DEPTH - 1);

    logic           rs_gt1, rs_gt0, rt_gt1, rt_gt0;
    logic           src_hit;
    logic           stall;
    logic           issue;
    logic           take_redirect;
    logic           flushing;
    logic [FCW-1:0] fcnt_q, fcnt_d;
    hz_state_t      state_q, state_d;

    hz_scoreboard #(
        .REG_AW   (REG_AW),
        .ALU_LAT  (ALU_LAT),
        .LOAD_LAT (LOAD_LAT)
    ) u_scoreboard (
        .clk     (clk),
        .rst_n   (rst_n),
        .advance (!mem_busy),
        .issue   (issue),
        .is_load (id_mem_read),
        .dst     (id_dst),
        .rs      (id_rs),
        .rt      (id_rt),
        .rs_gt1  (rs_gt1),
        .rs_gt0  (rs_gt0),
        .rt_gt1  (rt_gt1),
        .rt_gt0  (rt_gt0)
    );

    // Branches compare in ID, so they need the value one cycle earlier than EX consumers.
    always_comb begin
        if (id_branch) begin
            src_hit = (id_use_rs && rs_gt0) || (id_use_rt && rt_gt0);
        end else begin
            src_hit = (id_use_rs && rs_gt1) || (id_use_rt && rt_gt1);
        end
    end

    // stall is the effective one: a freeze outranks it.
    assign stall         = id_valid && src_hit && !mem_busy;
    assign issue         = id_valid && !stall && !mem_busy && id_reg_write && (id_dst != '0);
    // A stalled branch has not resolved yet, so its redirect is not taken.
    assign take_redirect = redirect && !stall && !mem_busy;
    // Zeroing IF/ID while stalled would destroy the held instruction, so stall masks it.
    assign flushing      = !mem_busy && !stall && (take_redirect || (fcnt_q != '0));

    always_comb begin
        fcnt_d = fcnt_q;
        if (!mem_busy) begin
            if (take_redirect) begin
                fcnt_d = FLUSH_RELOAD;
            end else if (fcnt_q != '0) begin
                fcnt_d = fcnt_q - 1'b1;
            end
        end
    end

    always_comb begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        idex_nop   = 1'b0;
        if_nop     = 1'b0;
        state_d    = HZ_RUN;
        if (mem_busy) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            state_d    = HZ_FREEZE;
        end else if (stall) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_nop   = 1'b1;
            state_d    = HZ_STALL;
        end else if (flushing) begin
            if_nop     = 1'b1;
            state_d    = HZ_FLUSH;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt_q  <= '0;
            state_q <= HZ_RUN;
        end else begin
            fcnt_q  <= fcnt_d;
            state_q <= state_d;
        end
    end

    assign hz_state = state_q;

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (if_nop && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_cycles = flush_cnt_q;
`else
    assign stall_cycles = '0;
    assign flush_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard_ctrl.sv
// Directed bench for hazard_scoreboard_ctrl (FLUSH_DEPTH = 3, other parameters default).
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_hazard_scoreboard_ctrl;

    // {pc_write, ifid_write, idex_nop, if_nop}
    localparam logic [3:0] RUN = 4'b1100;
    localparam logic [3:0] STL = 4'b0010;
    localparam logic [3:0] FLS = 4'b1101;
    localparam logic [3:0] FRZ = 4'b0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        id_valid = 1'b0;
    logic [4:0]  id_rs = '0;
    logic [4:0]  id_rt = '0;
    logic        id_use_rs = 1'b0;
    logic        id_use_rt = 1'b0;
    logic        id_branch = 1'b0;
    logic [4:0]  id_dst = '0;
    logic        id_reg_write = 1'b0;
    logic        id_mem_read = 1'b0;
    logic        redirect = 1'b0;
    logic        mem_busy = 1'b0;
    logic        pc_write, ifid_write, idex_nop, if_nop;
    logic [1:0]  hz_state;
    logic [31:0] stall_cycles, flush_cycles;
    logic [3:0]  ctl;

    int n_checks = 0;
    int n_errors = 0;

    assign ctl = {pc_write, ifid_write, idex_nop, if_nop};

    hazard_scoreboard_ctrl #(
        .FLUSH_DEPTH (3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_use_rs    (id_use_rs),
        .id_use_rt    (id_use_rt),
        .id_branch    (id_branch),
        .id_dst       (id_dst),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .redirect     (redirect),
        .mem_busy     (mem_busy),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .idex_nop     (idex_nop),
        .if_nop       (if_nop),
        .hz_state     (hz_state),
        .stall_cycles (stall_cycles),
        .flush_cycles (flush_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic br,
                         input logic [4:0] dst, input logic rw, input logic mr,
                         input logic rd, input logic busy);
        id_valid     = v;
        id_rs        = rs;
        id_rt        = rt;
        id_use_rs    = urs;
        id_use_rt    = urt;
        id_branch    = br;
        id_dst       = dst;
        id_reg_write = rw;
        id_mem_read  = mr;
        redirect     = rd;
        mem_busy     = busy;
    endtask

    // One cycle: drive, sample at the falling edge, return 1 unit after the next rising edge.
    task automatic step(input string tag, input logic v, input logic [4:0] rs,
                        input logic [4:0] rt, input logic urs, input logic urt, input logic br,
                        input logic [4:0] dst, input logic rw, input logic mr, input logic rd,
                        input logic busy, input logic [3:0] exp);
        drive(v, rs, rt, urs, urt, br, dst, rw, mr, rd, busy);
        @(negedge clk);
        check(tag, 32'(ctl), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    task automatic nop(input string tag, input logic [3:0] exp);
        step(tag, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, exp);
    endtask

    task automatic alu(input string tag, input logic [4:0] dst, input logic [4:0] rs,
                       input logic [4:0] rt, input logic busy, input logic [3:0] exp);
        step(tag, 1'b1, rs, rt, 1'b1, 1'b1, 1'b0, dst, 1'b1, 1'b0, 1'b0, busy, exp);
    endtask

    task automatic lw(input string tag, input logic [4:0] dst, input logic [4:0] rs,
                      input logic [3:0] exp);
        step(tag, 1'b1, rs, 5'd0, 1'b1, 1'b0, 1'b0, dst, 1'b1, 1'b1, 1'b0, 1'b0, exp);
    endtask

    task automatic beq(input string tag, input logic [4:0] rs, input logic [4:0] rt,
                       input logic rd, input logic [3:0] exp);
        step(tag, 1'b1, rs, rt, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, rd, 1'b0, exp);
    endtask

    initial begin
        // Reset
        #1 rst_n = 1'b0;
        #2;
        check("rst_ctl", 32'(ctl), 32'(RUN));
        check("rst_state", 32'(hz_state), 32'd0);
        check("rst_stall_cnt", stall_cycles, 32'd0);
        check("rst_flush_cnt", flush_cycles, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: load -> use, one stall
        lw("t1_lw", 5'd2, 5'd1, RUN);
        alu("t1_use_stall", 5'd4, 5'd2, 5'd1, 1'b0, STL);
        check("t1_state_stall", 32'(hz_state), 32'd1);
        alu("t1_use_go", 5'd4, 5'd2, 5'd1, 1'b0, RUN);
        check("t1_state_run", 32'(hz_state), 32'd0);
        for (int i = 0; i < 3; i++) nop("t1_drain", RUN);

        // 2: load -> branch, two stalls, then a 3-cycle flush
        lw("t2_lw", 5'd2, 5'd1, RUN);
        beq("t2_br_stall0", 5'd2, 5'd0, 1'b1, STL);
        beq("t2_br_stall1", 5'd2, 5'd0, 1'b1, STL);
        beq("t2_br_redirect", 5'd2, 5'd0, 1'b1, FLS);
        check("t2_state_flush", 32'(hz_state), 32'd2);
        nop("t2_flush1", FLS);
        nop("t2_flush2", FLS);
        nop("t2_flush_done", RUN);

        // 3: ALU -> use (no stall), ALU -> branch (one stall), r0 never stalls
        alu("t3_add_r3", 5'd3, 5'd1, 5'd1, 1'b0, RUN);
        alu("t3_use_r3", 5'd5, 5'd3, 5'd1, 1'b0, RUN);
        nop("t3_gap0", RUN);
        nop("t3_gap1", RUN);
        alu("t3_add_r3b", 5'd3, 5'd1, 5'd1, 1'b0, RUN);
        beq("t3_br_stall", 5'd3, 5'd1, 1'b0, STL);
        beq("t3_br_go", 5'd3, 5'd1, 1'b0, RUN);
        nop("t3_gap2", RUN);
        alu("t3_wr_r0", 5'd0, 5'd1, 5'd1, 1'b0, RUN);
        beq("t3_br_r0", 5'd0, 5'd0, 1'b0, RUN);
        lw("t3_lw_r0", 5'd0, 5'd1, RUN);
        alu("t3_rd_r0", 5'd6, 5'd0, 5'd0, 1'b0, RUN);
        beq("t3_br_r0b", 5'd0, 5'd0, 1'b0, RUN);
        nop("t3_gap3", RUN);
        nop("t3_gap4", RUN);

        // 4: freeze in the middle of a load-use stall
        lw("t4_lw", 5'd2, 5'd1, RUN);
        alu("t4_frz0", 5'd4, 5'd2, 5'd1, 1'b1, FRZ);
        check("t4_state_frz", 32'(hz_state), 32'd3);
        alu("t4_frz1", 5'd4, 5'd2, 5'd1, 1'b1, FRZ);
        alu("t4_frz2", 5'd4, 5'd2, 5'd1, 1'b1, FRZ);
        alu("t4_stall", 5'd4, 5'd2, 5'd1, 1'b0, STL);
        alu("t4_go", 5'd4, 5'd2, 5'd1, 1'b0, RUN);
        for (int i = 0; i < 3; i++) nop("t4_drain", RUN);

        // 5: redirect on two consecutive cycles -> if_nop on cycles 0..3
        beq("t5_rd0", 5'd0, 5'd0, 1'b1, FLS);
        beq("t5_rd1", 5'd0, 5'd0, 1'b1, FLS);
        nop("t5_c2", FLS);
        nop("t5_c3", FLS);
        nop("t5_c4", RUN);

`ifdef HAZARD_STATS_EN
        // Stalls: t1 1 + t2 2 + t3 1 + t4 1. Flushes: t2 3 + t5 4.
        check("stats_stall", stall_cycles, 32'd5);
        check("stats_flush", flush_cycles, 32'd7);
`else
        check("stats_stall_off", stall_cycles, 32'd0);
        check("stats_flush_off", flush_cycles, 32'd0);
`endif

        // 6: reset mid-stall clears everything asynchronously
        lw("t6_lw", 5'd2, 5'd1, RUN);
        drive(1'b1, 5'd2, 5'd1, 1'b1, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("t6_stall", 32'(ctl), 32'(STL));
        #1 rst_n = 1'b0;
        #1;
        check("t6_async_ctl", 32'(ctl), 32'(RUN));
        check("t6_async_state", 32'(hz_state), 32'd0);
        check("t6_async_stall_cnt", stall_cycles, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        alu("t6_after_rst", 5'd4, 5'd2, 5'd1, 1'b0, RUN);
        check("t6_flush_cnt", flush_cycles, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
